// File: rtl/bit_serial_alu_ctrl_if.sv
// Purpose : request/result bus between the control unit and the bit-serial ALU sequencer.
// Latency : wires only, no state.
// Backpressure: none here; the requester watches busy/done to know when a new start is taken.
// Signals : start/op/a/b flow requester -> sequencer; busy/done/result/cout/ovf/zero flow back.
interface bit_serial_alu_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    // Control unit side
    modport master (
        output start, op, a, b,
        input  busy, done, result, cout, ovf, zero
    );

    // Sequencer side
    modport slave (
        input  start, op, a, b,
        output busy, done, result, cout, ovf, zero
    );
endinterface

// File: rtl/bit_serial_alu_ctrl.sv
// Purpose : runs WIDTH-bit ALU ops LSB-first through an external 1-bit slice, one bit per clock.
// Latency : start taken at edge 0, WIDTH RUN cycles, done pulses in cycle WIDTH+1.
// Backpressure: start is only taken in IDLE or DONE; start while busy is dropped, not queued.
// Ports   : clk, rst (sync, active high); bus = request/result interface (slave side);
//           slice_a/b/cin/l/s drive the slice, slice_f/slice_cout come back in the same cycle.
module bit_serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    bit_serial_alu_ctrl_if.slave        bus,
    output logic                        slice_a,
    output logic                        slice_b,
    output logic                        slice_cin,
    output logic                        slice_l,
    output logic [2:0]                  slice_s,
    input  logic                        slice_f,
    input  logic                        slice_cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             busy, done, accept, last;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] res_sh;   // the LSB of the assembly falls off on the last shift
    logic [WIDTH-1:0] res_next;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             c_msb_in;
    logic             arith;

    logic [WIDTH-1:0] result_q;
    logic             cout_q, ovf_q, zero_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                // A start here goes straight back to RUN with no idle gap
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign last = (state_q == S_RUN) && (cnt_q == LAST_BIT);

    // ---------------- slice drive ----------------
    // Carry doubles as the decrement borrow input so both slice inputs see carry_q.
    assign slice_a   = busy & a_sh[0];
    assign slice_b   = busy & b_sh[0];
    assign slice_cin = busy & carry_q;
    assign slice_l   = busy & carry_q;
    assign slice_s   = busy ? op_q : 3'b000;

    assign arith    = ~op_q[2];
    // On the final bit carry_q is the carry into the MSB, which with the MSB carry-out gives overflow
    assign c_msb_in = carry_q;
    assign res_next = {slice_f, res_sh};

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            op_q     <= 3'b000;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            op_q    <= bus.op;
            cnt_q   <= '0;
            // inc and sub need a +1 injected at the LSB
            carry_q <= (bus.op == 3'b000) || (bus.op == 3'b010);
        end else if (busy) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            res_sh  <= res_next[WIDTH-1:1];
            carry_q <= arith & slice_cout;
            if (last) begin
                result_q <= res_next;
                cout_q   <= arith & slice_cout;
                ovf_q    <= arith & (c_msb_in ^ slice_cout);
                zero_q   <= (res_next == '0);
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Purpose : bench for bit_serial_alu_ctrl with a behavioural 1-bit slice attached.
// Latency : checks done arrives WIDTH+1 cycles after the accepting edge.
// Backpressure: exercises start ignored while busy and start held in DONE.
module tb_bit_serial_alu_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bit_serial_alu_ctrl_if #(.WIDTH(W)) bus ();

    logic       slice_a, slice_b, slice_cin, slice_l, slice_f, slice_cout;
    logic [2:0] slice_s;

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_l    (slice_l),
        .slice_s    (slice_s),
        .slice_f    (slice_f),
        .slice_cout (slice_cout)
    );

    // 1-bit ALU slice: full adder for inc/add/sub, all-ones addend for dec, plain gates otherwise
    always_comb begin
        slice_f    = 1'b0;
        slice_cout = 1'b0;
        case (slice_s)
            3'b000: begin slice_f = slice_a ^ slice_cin;            slice_cout = slice_a & slice_cin; end
            3'b001: begin
                slice_f    = slice_a ^ slice_b ^ slice_cin;
                slice_cout = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
            end
            3'b010: begin
                slice_f    = slice_a ^ ~slice_b ^ slice_cin;
                slice_cout = (slice_a & ~slice_b) | (slice_a & slice_cin) | (~slice_b & slice_cin);
            end
            3'b011: begin slice_f = ~(slice_a ^ slice_l);           slice_cout = slice_a | slice_l; end
            3'b100: slice_f = slice_a & slice_b;
            3'b101: slice_f = slice_a | slice_b;
            3'b110: slice_f = slice_a ^ slice_b;
            default: slice_f = ~slice_a;
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed/unsigned arithmetic straight from the opcode meaning
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic c, output logic v, output logic z);
        int sa, sb, sr;
        sa = $signed(a);
        sb = $signed(b);
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            3'd0: begin r = a + 1'b1; c = (a == 8'hFF); v = (sa + 1 > 127); end
            3'd1: begin r = a + b; c = (int'(a) + int'(b) > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            3'd2: begin r = a - b; c = (a >= b); sr = sa - sb; v = (sr > 127) || (sr < -128); end
            3'd3: begin r = a - 1'b1; c = (a != 0); v = (sa - 1 < -128); end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = ~a;
        endcase
        z = (r == 0);
    endtask

    // Issues one op (start driven in the current cycle) and returns the flags seen on done
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit glitch, input string tag,
                          output logic [W-1:0] r, output logic c, output logic v, output logic z);
        int n, busy_n;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
        n      = 1;
        busy_n = 0;
        while (!bus.done && n < 4 * W) begin
            if (bus.busy) busy_n++;
            if (glitch && n == 4) begin
                bus.start = 1'b1;
                bus.op    = ~op;
                bus.a     = ~a;
                bus.b     = b + 8'h33;
            end
            if (glitch && n == 5) bus.start = 1'b0;
            tick();
            n++;
        end
        chk({tag, " latency"}, n, W + 1);
        chk({tag, " busy_cycles"}, busy_n, W);
        chk({tag, " busy_in_done"}, bus.busy, 1'b0);
        r = bus.result;
        c = bus.cout;
        v = bus.ovf;
        z = bus.zero;
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, r;
        logic         c, v, z;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [W-1:0] r, er;
        logic c, v, z, ec, ev, ez;
        int done_seen;

        vecs[0] = '{3'd1, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{3'd2, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{3'd2, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{3'd0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{3'd3, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{3'd3, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{3'd6, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{3'd7, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{3'd4, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{3'd5, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) tick();
        chk("reset busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        chk("reset result", bus.result, 32'd0);
        chk("reset flags", {bus.cout, bus.ovf, bus.zero}, 32'd0);
        chk("reset slice", {slice_a, slice_b, slice_cin, slice_l, slice_s}, 32'd0);
        rst = 1'b0;
        tick();

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, $sformatf("vec%0d", i), r, c, v, z);
            chk($sformatf("vec%0d result", i), r, vecs[i].r);
            chk($sformatf("vec%0d cout", i), c, vecs[i].c);
            chk($sformatf("vec%0d ovf", i), v, vecs[i].v);
            chk($sformatf("vec%0d zero", i), z, vecs[i].z);
            tick();
            chk($sformatf("vec%0d idle_after", i), {bus.busy, bus.done}, 2'b00);
        end

        // start pulsed mid-RUN with different operands is ignored
        run_op(3'd1, 8'h5A, 8'h3C, 1'b1, "glitch", r, c, v, z);
        chk("glitch result", r, 8'h96);
        chk("glitch flags", {c, v, z}, 3'b010);
        tick();
        chk("glitch no_second_run", {bus.busy, bus.done}, 2'b00);

        // start held in DONE: second op accepted with no IDLE gap (latency check inside)
        run_op(3'd2, 8'h10, 8'h20, 1'b0, "b2b_first", r, c, v, z);
        chk("b2b_first result", r, 8'hF0);
        run_op(3'd2, 8'h80, 8'h01, 1'b0, "b2b_second", r, c, v, z);
        chk("b2b_second result", r, 8'h7F);
        chk("b2b_second flags", {c, v}, 2'b11);
        tick();

        // Reset in cycle 5 of RUN aborts everything
        bus.start = 1'b1;
        bus.op    = 3'd1;
        bus.a     = 8'h03;
        bus.b     = 8'h04;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        chk("midrst busy_before", bus.busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst busy/done", {bus.busy, bus.done}, 2'b00);
        chk("midrst result", bus.result, 32'd0);
        chk("midrst flags", {bus.cout, bus.ovf, bus.zero}, 3'b000);
        chk("midrst slice_s", slice_s, 3'b000);
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done) done_seen++;
            tick();
        end
        chk("midrst no_done", done_seen, 0);
        run_op(3'd1, 8'h01, 8'h01, 1'b0, "after_rst", r, c, v, z);
        chk("after_rst result", r, 8'h02);
        chk("after_rst flags", {c, v, z}, 3'b000);
        tick();

        // Randomized ops against the reference model, some back-to-back
        for (int i = 0; i < 40; i++) begin
            logic [2:0]   op;
            logic [W-1:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (i % 5 == 0) a = 8'h80 ^ 8'($urandom_range(0, 1));
            if (i % 7 == 0) a = 8'h7F;
            model(op, a, b, er, ec, ev, ez);
            run_op(op, a, b, 1'b0, $sformatf("rnd%0d", i), r, c, v, z);
            chk($sformatf("rnd%0d op%0d a=%0h b=%0h", i, op, a, b), {r, c, v, z}, {er, ec, ev, ez});
            if ($urandom_range(0, 1) == 0) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
